// File: rtl/ex_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MUL/DIV/MOD,
// branch resolution against registered flags, and the EX/MA pipeline latch.
module ex_stage_mc #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CTRL_W  = 22,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_flush,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [31:0]       in_ir,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [3:0]        in_op,
  input  logic [1:0]        in_br,
  input  logic [DATA_W-1:0] in_br_target,
  input  logic [DATA_W-1:0] in_opa,
  input  logic [DATA_W-1:0] in_opb,
  input  logic [DATA_W-1:0] in_op2,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [1:0]        fwd_2,
  input  logic [DATA_W-1:0] rw_data,
  input  logic [DATA_W-1:0] ma_result,
  output logic              stall,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_pc,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pc,
  output logic [31:0]       out_ir,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_op2
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_NOT = 4'd4,
    OP_MOV = 4'd5, OP_LSL = 4'd6, OP_LSR = 4'd7, OP_ASR = 4'd8, OP_CMP = 4'd9,
    OP_MUL = 4'd10, OP_DIV = 4'd11, OP_MOD = 4'd12
  } op_t;

  localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(DATA_W - 1);

  state_t              state_q, state_d;
  op_t                 op;
  logic [DATA_W-1:0]   a_v, b_v, op2_v, alu_result, mc_result;
  logic [SHAMT_W-1:0]  shamt, cnt_q;
  logic [DATA_W-1:0]   a_q, b_q, op2_q, acc_q, quo_q;
  logic [DATA_W:0]     rem_ext, rem_diff;
  logic                rem_ge, is_mc, div_zero;
  logic                flag_e, flag_gt;
  logic                stall_c, accept_sc, accept_mc, mc_start;

  function automatic logic [DATA_W-1:0] fwd_sel(input logic [1:0] sel,
                                                input logic [DATA_W-1:0] reg_v,
                                                input logic [DATA_W-1:0] rw_v,
                                                input logic [DATA_W-1:0] ma_v);
    case (sel)
      2'd1:    return rw_v;
      2'd2:    return ma_v;
      default: return reg_v;
    endcase
  endfunction

  assign op       = op_t'(in_op);
  assign a_v      = fwd_sel(fwd_a, in_opa, rw_data, ma_result);
  assign b_v      = fwd_sel(fwd_b, in_opb, rw_data, ma_result);
  assign op2_v    = fwd_sel(fwd_2, in_op2, rw_data, ma_result);
  assign shamt    = b_v[SHAMT_W-1:0];
  assign is_mc    = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  assign div_zero = (op != OP_MUL) && (b_v == '0);

  always_comb begin
    alu_result = b_v;
    case (op)
      OP_ADD:         alu_result = a_v + b_v;
      OP_SUB, OP_CMP: alu_result = a_v - b_v;
      OP_AND:         alu_result = a_v & b_v;
      OP_OR:          alu_result = a_v | b_v;
      OP_NOT:         alu_result = ~b_v;
      OP_LSL:         alu_result = a_v << shamt;
      OP_LSR:         alu_result = a_v >> shamt;
      OP_ASR:         alu_result = DATA_W'($signed(a_v) >>> shamt);
      default:        alu_result = b_v;
    endcase
  end

  // Restoring divide step: acc_q holds the partial remainder, quo_q shifts the
  // dividend out at the top while quotient bits enter at the bottom.
  assign rem_ext   = {acc_q, quo_q[DATA_W-1]};
  assign rem_diff  = rem_ext - {1'b0, b_q};
  assign rem_ge    = ~rem_diff[DATA_W];
  assign mc_result = (op == OP_DIV) ? quo_q : acc_q;

  always_comb begin
    state_d   = state_q;
    stall_c   = 1'b0;
    accept_sc = 1'b0;
    accept_mc = 1'b0;
    mc_start  = 1'b0;
    if (in_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          if (is_mc) begin
            stall_c  = 1'b1;
            mc_start = 1'b1;
            state_d  = div_zero ? S_DONE : S_BUSY;
          end else begin
            accept_sc = 1'b1;
          end
        end
        S_BUSY: begin
          stall_c = 1'b1;
          if (cnt_q == LAST_STEP) state_d = S_DONE;
        end
        S_DONE: begin
          accept_mc = in_valid;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign stall        = stall_c & ~reset;
  assign branch_pc    = in_br_target;
  assign branch_taken = in_valid && !in_flush &&
                        ((in_br == 2'd1) || (in_br == 2'd2 && flag_e) || (in_br == 2'd3 && flag_gt));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op2_q      <= '0;
      acc_q      <= '0;
      quo_q      <= '0;
      flag_e     <= 1'b0;
      flag_gt    <= 1'b0;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_ir     <= '0;
      out_ctrl   <= '0;
      out_result <= '0;
      out_op2    <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= accept_sc | accept_mc;
      if (in_flush) begin
        cnt_q <= '0;
      end else if (mc_start) begin
        // Divide-by-zero preloads the final DIV/MOD answers and skips BUSY.
        cnt_q <= '0;
        a_q   <= a_v;
        b_q   <= b_v;
        op2_q <= op2_v;
        acc_q <= div_zero ? a_v : '0;
        quo_q <= div_zero ? '1 : a_v;
      end else if (state_q == S_BUSY) begin
        cnt_q <= cnt_q + SHAMT_W'(1);
        if (op == OP_MUL) begin
          acc_q <= acc_q + (b_q[cnt_q] ? (a_q << cnt_q) : '0);
        end else begin
          acc_q <= rem_ge ? rem_diff[DATA_W-1:0] : rem_ext[DATA_W-1:0];
          quo_q <= {quo_q[DATA_W-2:0], rem_ge};
        end
      end
      if (accept_sc || accept_mc) begin
        out_pc   <= in_pc;
        out_ir   <= in_ir;
        out_ctrl <= in_ctrl;
      end
      if (accept_sc) begin
        out_result <= alu_result;
        out_op2    <= op2_v;
        if (op == OP_CMP) begin
          flag_e  <= (a_v == b_v);
          flag_gt <= ($signed(a_v) > $signed(b_v));
        end
      end
      if (accept_mc) begin
        out_result <= mc_result;
        out_op2    <= op2_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc; expected EX/MA contents are queued with the
// cycle they are due and checked against the latch every cycle.
module tb_ex_stage_mc;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 22;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, NOT_ = 4'd4, MOV = 4'd5,
                         LSL = 4'd6, LSR = 4'd7, ASR = 4'd8, CMP = 4'd9,
                         MUL = 4'd10, DIV = 4'd11, MOD = 4'd12;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_flush;
  logic [DW-1:0] in_pc, in_br_target, in_opa, in_opb, in_op2, rw_data, ma_result;
  logic [31:0]   in_ir;
  logic [CW-1:0] in_ctrl;
  logic [3:0]    in_op;
  logic [1:0]    in_br, fwd_a, fwd_b, fwd_2;
  logic          stall, branch_taken, out_valid;
  logic [DW-1:0] branch_pc, out_pc, out_result, out_op2;
  logic [31:0]   out_ir;
  logic [CW-1:0] out_ctrl;

  ex_stage_mc #(.DATA_W(DW), .CTRL_W(CW), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_flush(in_flush),
    .in_pc(in_pc), .in_ir(in_ir), .in_ctrl(in_ctrl), .in_op(in_op), .in_br(in_br),
    .in_br_target(in_br_target), .in_opa(in_opa), .in_opb(in_opb), .in_op2(in_op2),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_2(fwd_2), .rw_data(rw_data), .ma_result(ma_result),
    .stall(stall), .branch_taken(branch_taken), .branch_pc(branch_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_ir(out_ir), .out_ctrl(out_ctrl),
    .out_result(out_result), .out_op2(out_op2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] res;
    logic [DW-1:0] op2;
    logic [DW-1:0] pc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [DW-1:0] pc_e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      pc_e = sb[0].pc;
      chk("out_valid", {31'b0, out_valid}, 32'd1);
      chk("out_result", out_result, sb[0].res);
      chk("out_op2", out_op2, sb[0].op2);
      chk("out_pc", out_pc, pc_e);
      chk("out_ir", out_ir, ~pc_e);
      chk("out_ctrl", {10'b0, out_ctrl}, {10'b0, pc_e[CW-1:0]});
      void'(sb.pop_front());
    end else begin
      chk("bubble", {31'b0, out_valid}, 32'd0);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] pc);
    in_valid = 1'b1; in_op = op; in_opa = a; in_opb = b; in_op2 = pc + 32'd1;
    in_pc = pc; in_ir = ~pc; in_ctrl = pc[CW-1:0];
    in_br = 2'd0; fwd_a = 2'd0; fwd_b = 2'd0; fwd_2 = 2'd0;
    #1;
  endtask

  task automatic push(input int unsigned lat, input logic [DW-1:0] res,
                      input logic [DW-1:0] op2, input logic [DW-1:0] pc);
    sb.push_back('{cyc + lat, res, op2, pc});
  endtask

  task automatic sc(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                    input logic [DW-1:0] pc, input logic [DW-1:0] res);
    issue(op, a, b, pc);
    chk("sc_stall", {31'b0, stall}, 32'd0);
    push(1, res, pc + 32'd1, pc);
    tick();
  endtask

  task automatic mc(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                    input logic [DW-1:0] pc, input logic [DW-1:0] res, input int unsigned n);
    issue(op, a, b, pc);
    push(n + 1, res, pc + 32'd1, pc);
    for (int unsigned i = 0; i < n; i++) begin
      chk("mc_stall", {31'b0, stall}, 32'd1);
      tick();
    end
    chk("mc_done_stall", {31'b0, stall}, 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_flush = 1'b0; in_pc = '0; in_ir = '0; in_ctrl = '0;
    in_op = '0; in_br = '0; in_br_target = '0; in_opa = '0; in_opb = '0; in_op2 = '0;
    fwd_a = '0; fwd_b = '0; fwd_2 = '0; rw_data = '0; ma_result = '0;
    tick();
    tick();
    chk("rst_result", out_result, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;

    sc(ADD, 32'hFFFF_FFFF, 32'd2, 32'h100, 32'h0000_0001);
    in_valid = 1'b0;
    tick();

    issue(SUB, 32'd1, 32'd9, 32'h104);
    fwd_a = 2'd2; ma_result = 32'd7; fwd_b = 2'd1; fwd_2 = 2'd1; rw_data = 32'd3;
    #1;
    push(1, 32'd4, 32'd3, 32'h104);
    tick();

    sc(LSL, 32'd1, 32'h23, 32'h108, 32'd8);
    sc(LSR, 32'h8000_0000, 32'd4, 32'h10C, 32'h0800_0000);
    sc(ASR, 32'h8000_0000, 32'd4, 32'h110, 32'hF800_0000);
    sc(NOT_, 32'd0, 32'h0F0F_0F0F, 32'h114, 32'hF0F0_F0F0);
    sc(4'd15, 32'd0, 32'h1234, 32'h118, 32'h1234);

    sc(CMP, 32'd5, 32'd5, 32'h120, 32'd0);
    issue(MOV, 32'd0, 32'hAB, 32'h124);
    in_br = 2'd2; in_br_target = 32'h200;
    #1;
    chk("beq_taken", {31'b0, branch_taken}, 32'd1);
    chk("branch_pc", branch_pc, 32'h200);
    push(1, 32'hAB, 32'h125, 32'h124);
    tick();

    sc(CMP, 32'hFFFF_FFFF, 32'd1, 32'h128, 32'hFFFF_FFFE);
    issue(MOV, 32'd0, 32'hCD, 32'h12C);
    in_br = 2'd3;
    #1;
    chk("bgt_signed", {31'b0, branch_taken}, 32'd0);
    push(1, 32'hCD, 32'h12D, 32'h12C);
    tick();

    mc(MUL, 32'h0001_0000, 32'h0001_0001, 32'h200, 32'h0001_0000, 33);
    mc(DIV, 32'd100, 32'd7, 32'h204, 32'd14, 33);
    mc(MOD, 32'd100, 32'd7, 32'h208, 32'd2, 33);
    mc(DIV, 32'd9, 32'd0, 32'h20C, 32'hFFFF_FFFF, 1);
    mc(MOD, 32'd9, 32'd0, 32'h210, 32'd9, 1);

    issue(MUL, 32'd3, 32'd5, 32'h300);
    repeat (11) tick();
    chk("pre_flush_stall", {31'b0, stall}, 32'd1);
    in_flush = 1'b1;
    #1;
    chk("flush_stall", {31'b0, stall}, 32'd0);
    tick();
    in_flush = 1'b0; in_valid = 1'b0;
    repeat (3) tick();

    sc(CMP, 32'd3, 32'd3, 32'h400, 32'd0);
    issue(MOV, 32'd0, 32'h77, 32'h404);
    in_br = 2'd2;
    #1;
    chk("beq_pre_rst", {31'b0, branch_taken}, 32'd1);
    push(1, 32'h77, 32'h405, 32'h404);
    tick();
    issue(MUL, 32'd3, 32'd5, 32'h408);
    repeat (10) tick();
    reset = 1'b1; in_valid = 1'b0;
    tick();
    chk("mid_rst_result", out_result, 32'd0);
    chk("mid_rst_pc", out_pc, 32'd0);
    chk("mid_rst_ir", out_ir, 32'd0);
    chk("mid_rst_op2", out_op2, 32'd0);
    chk("mid_rst_stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;
    issue(MOV, 32'd0, 32'h99, 32'h40C);
    in_br = 2'd2;
    #1;
    chk("beq_post_rst", {31'b0, branch_taken}, 32'd0);
    push(1, 32'h99, 32'h40D, 32'h40C);
    tick();
    in_valid = 1'b0;
    tick();

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised execute stage for the pipelined processor. Sits between the OF/EX and EX/MA boundaries.
- Selects forwarded operands from the MA and RW stages and executes single-cycle ALU ops.
- Runs iterative multi-cycle MUL/DIV/MOD, stalling upstream while they run.
- Resolves branches against a registered flags register and drives a registered EX/MA pipeline latch.

Parameters:
DATA_W, 32, datapath width (power of 2, >=8)
CTRL_W, 22, width of control bus passed through to MA
SHAMT_W, 5, shift-amount bits, = log2(DATA_W)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  instruction present at EX input
in_flush  in  1  kill instruction in EX (branch mispredict)
in_pc  in  DATA_W  instruction PC
in_ir  in  32  instruction word, passed through
in_ctrl  in  CTRL_W  control bus, passed through
in_op  in  4  0 ADD,1 SUB,2 AND,3 OR,4 NOT,5 MOV,6 LSL,7 LSR,8 ASR,9 CMP,10 MUL,11 DIV,12 MOD; 13-15 behave as MOV
in_br  in  2  0 none,1 unconditional,2 BEQ,3 BGT
in_br_target  in  DATA_W  branch target
in_opa, in_opb, in_op2  in  DATA_W  register-file operands (op2 = store data)
fwd_a, fwd_b, fwd_2  in  2  0 register,1 RW data,2 MA result,3 register
rw_data  in  DATA_W  RW-stage writeback value
ma_result  in  DATA_W  MA-stage ALU result
stall  out  1  hold upstream stages and inputs
branch_taken  out  1  combinational branch decision
branch_pc  out  DATA_W  combinational, = in_br_target
out_valid  out  1  EX/MA latch valid
out_pc, out_ir, out_ctrl, out_result, out_op2  out  as inputs  EX/MA latch contents

Behaviour:
- Reset: state IDLE; flags {E,GT}=0; all out_* 0; stall 0; counter 0.
- Forwarding is combinational on the selected operands A, B and 2 (fwd code 3 = register).
- Single-cycle ops accept when in_valid && !stall && !in_flush. EX/MA latch loads at the next edge. Latency 1.
- Idle: with no accept, out_valid <= 0 at the next edge (bubble).
- Arithmetic: ADD/SUB wrap mod 2^DATA_W. NOT = ~B. MOV = B.
- Shifts: amount = B[SHAMT_W-1:0]. ASR sign-fills from A.
- CMP result = A-B; at the accept edge flags E <= (A==B), GT <= ($signed(A)>$signed(B)). No other op writes flags.
- Branches: taken = in_valid && !in_flush && (br==1 || (br==2 && E) || (br==3 && GT)). Uses flags as registered before this instruction. A CMP immediately followed by a branch therefore uses the CMP's flags.
- Multi-cycle FSM: IDLE, BUSY, DONE.
  - IDLE with valid MUL/DIV/MOD: latch A, B, op2; counter=0; go BUSY. stall=1 in this cycle, out_valid<=0.
  - BUSY: one shift-add (MUL, unsigned, low DATA_W bits kept) or restoring-divide (DIV/MOD, unsigned) step per cycle. stall=1. Go DONE when counter==DATA_W-1.
  - DONE: stall=0. The held instruction is accepted this cycle with the iterative result; latch loads and FSM returns to IDLE at this edge.
  - Total: DATA_W+2 cycles from first presentation to out_valid.
- Divide by zero: skip BUSY; IDLE->DONE directly. DIV = all ones, MOD = A.
- Upstream must hold all inputs stable while stall=1. Forwarded operands are sampled only at BUSY entry.
- in_flush in any state: FSM -> IDLE, counter cleared, out_valid<=0, flags unchanged, stall=0 in that cycle.
- Reset mid-operation: same as the reset values above.

Test Plan:
- ADD, fwd_a=0: A=0xFFFFFFFF, B=2 -> out_result 0x00000001, out_valid=1 one edge after accept, stall never high.
- Forwarding: fwd_a=2, ma_result=7, in_opa=1; fwd_b=1, rw_data=3, op SUB -> out_result 4. Same with fwd_2=1 -> out_op2=3.
- CMP 5,5 then BEQ next cycle -> branch_taken=1, branch_pc=in_br_target. Then CMP -1,1, BGT -> branch_taken=0 (signed).
- MUL 0x10000 x 0x10001 -> stall high 33 cycles, out_valid 34 cycles after presentation, result 0x00010000. Intervening out_valid=0.
- DIV 100/7 -> 14; MOD -> 2. DIV 9/0 -> 0xFFFFFFFF after 2 cycles; MOD 9/0 -> 9.
- MUL in progress, assert in_flush at BUSY cycle 10 -> stall drops, no out_valid. Repeat with reset instead -> all outputs zero next edge.
